// File: rtl/silife_pkg.sv
// Shared MAX7219 register map, power-up word list and display FSM state type
// for the silife LED-matrix output stage.
package silife_pkg;

  localparam logic [3:0] DIGIT0    = 4'd1;
  localparam logic [3:0] DECODE    = 4'd9;
  localparam logic [3:0] INTENSITY = 4'd10;
  localparam logic [3:0] SCANLIMIT = 4'd11;
  localparam logic [3:0] SHUTDOWN  = 4'd12;
  localparam logic [3:0] TEST      = 4'd15;

  localparam int INIT_LEN = 5;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, TAIL, GAP} state_t;

  function automatic logic [15:0] dev_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  // Power-up sequence: test off, scan all 8 digits, raw mode, brightness, wake.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    case (idx)
      3'd0:    return dev_word(TEST, 8'h00);
      3'd1:    return dev_word(SCANLIMIT, 8'h07);
      3'd2:    return dev_word(DECODE, 8'h00);
      3'd3:    return dev_word(INTENSITY, {4'h0, inten});
      default: return dev_word(SHUTDOWN, 8'h01);
    endcase
  endfunction

endpackage

// File: rtl/silife_max7219_if.sv
// Frame request, grid row port and SPI pins between the cell grid and the
// MAX7219 display stage.
interface silife_max7219_if #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
);
  logic                      frame_req;
  logic [3:0]                intensity;
  logic [$clog2(HEIGHT)-1:0] row_addr;
  logic [WIDTH-1:0]          row_data;
  logic                      busy;
  logic                      frame_done;
  logic                      spi_cs;
  logic                      spi_sck;
  logic                      spi_mosi;

  modport master (output frame_req, intensity, row_data,
                  input  row_addr, busy, frame_done, spi_cs, spi_sck, spi_mosi);
  modport slave  (input  frame_req, intensity, row_data,
                  output row_addr, busy, frame_done, spi_cs, spi_sck, spi_mosi);
endinterface

// File: rtl/silife_spi_shifter.sv
// Serializes one 16-bit word MSB first; SCK low then high for CLK_DIV clocks per bit.
module silife_spi_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        ready,
  output logic        done,
  output logic        sck,
  output logic        mosi
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active;
  logic          high_ph;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [15:0]   sreg;
  logic          phase_end;

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  assign ready     = !active;
  assign mosi      = sreg[15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      high_ph <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sck     <= 1'b0;
      done    <= 1'b0;
      sreg    <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          high_ph <= 1'b0;
          bit_cnt <= 4'd15;
          div_cnt <= '0;
          sck     <= 1'b0;
          sreg    <= word;
        end
      end else if (!phase_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!high_ph) begin
          high_ph <= 1'b1;
          sck     <= 1'b1;
        end else begin
          // Falling edge: present the next bit, or finish with data held.
          high_ph <= 1'b0;
          sck     <= 1'b0;
          if (bit_cnt == 4'd0) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            sreg    <= {sreg[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/silife_max7219.sv
// Drives a chain of MAX7219 8x8 drivers: power-up config, then per-frame digit
// refresh from the grid row port. Devices are visited farthest (CHAIN-1) first.
module silife_max7219 import silife_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  silife_max7219_if.slave bus
);
  localparam int TW  = WIDTH / 8;
  localparam int TH  = HEIGHT / 8;
  localparam int CW  = (TW > 1) ? $clog2(TW) : 1;
  localparam int RW  = (TH > 1) ? $clog2(TH) : 1;
  localparam int AW  = $clog2(HEIGHT);
  localparam int GW  = $clog2(2 * CLK_DIV);

  state_t        state, state_nxt;
  logic          init_pending, frame_pending, is_init, done_q;
  logic [3:0]    seq, int_q, last_int;
  logic [CW-1:0] tcol;
  logic [RW-1:0] trow;
  logic [GW-1:0] cnt;
  logic [AW-1:0] row_q, fetch_row;
  logic [7:0]    row_byte;
  logic [15:0]   word_w;
  logic          start_init, start_frame, sh_start, sh_ready, sh_done;
  logic          cfg_word, last_dev, chain_last, int_change, tail_end, gap_end;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction

  assign cfg_word   = is_init || (seq == 4'd0);
  assign last_dev   = (trow == '0) && (tcol == '0);
  assign chain_last = is_init ? (seq == 4'(INIT_LEN - 1)) : (seq == 4'd8);
  assign int_change = (bus.intensity != last_int);
  assign tail_end   = (cnt == GW'(CLK_DIV - 1));
  assign gap_end    = (cnt == GW'(2 * CLK_DIV - 1));

  // Digit k of a tile comes from row tile_row*8+k-1; leftmost column lands in bit 7.
  assign fetch_row = AW'(int'(trow) * 8 + int'(seq) - 1);
  assign row_byte  = rev8(8'(bus.row_data >> {tcol, 3'b000}));
  assign word_w    = is_init        ? init_word(seq[2:0], int_q) :
                     (seq == 4'd0)  ? dev_word(INTENSITY, {4'h0, int_q}) :
                                      dev_word(DIGIT0 + seq - 4'd1, row_byte);

  assign bus.row_addr   = (state == FETCH) ? fetch_row : row_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = done_q;
  assign bus.spi_cs     = (state == IDLE) || (state == GAP);

  silife_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (sh_start),
    .word    (word_w),
    .ready   (sh_ready),
    .done    (sh_done),
    .sck     (bus.spi_sck),
    .mosi    (bus.spi_mosi)
  );

  always_comb begin
    state_nxt   = state;
    start_init  = 1'b0;
    start_frame = 1'b0;
    sh_start    = 1'b0;
    case (state)
      IDLE: begin
        if (init_pending) begin
          start_init = 1'b1;
          state_nxt  = CAPTURE;
        end else if (frame_pending) begin
          start_frame = 1'b1;
          state_nxt   = int_change ? CAPTURE : FETCH;
        end
      end
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: begin
        if (sh_ready) begin
          sh_start  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (sh_done) state_nxt = last_dev ? TAIL : (cfg_word ? CAPTURE : FETCH);
      TAIL:    if (tail_end) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = chain_last ? IDLE : (is_init ? CAPTURE : FETCH);
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      init_pending  <= 1'b1;
      frame_pending <= 1'b0;
      is_init       <= 1'b0;
      done_q        <= 1'b0;
      seq           <= '0;
      int_q         <= '0;
      last_int      <= '0;
      tcol          <= '0;
      trow          <= '0;
      cnt           <= '0;
      row_q         <= '0;
    end else begin
      state         <= state_nxt;
      frame_pending <= bus.frame_req | (frame_pending & ~start_frame);
      done_q        <= (state == GAP) && gap_end && chain_last && !is_init;
      cnt           <= ((state_nxt == state) && (state == TAIL || state == GAP)) ? cnt + 1'b1 : '0;
      if (state == FETCH) row_q <= fetch_row;
      if (start_init || start_frame) begin
        is_init <= start_init;
        int_q   <= bus.intensity;
        tcol    <= CW'(TW - 1);
        trow    <= RW'(TH - 1);
      end
      if (start_init) seq <= '0;
      if (start_frame) begin
        if (int_change) begin
          seq      <= '0;
          last_int <= bus.intensity;
        end else begin
          seq <= 4'd1;
        end
      end
      if (state == SHIFT && sh_done && !last_dev) begin
        if (tcol == '0) begin
          tcol <= CW'(TW - 1);
          trow <= trow - 1'b1;
        end else begin
          tcol <= tcol - 1'b1;
        end
      end
      if (state == GAP && gap_end) begin
        if (!chain_last) begin
          seq  <= seq + 1'b1;
          tcol <= CW'(TW - 1);
          trow <= RW'(TH - 1);
        end else if (is_init) begin
          init_pending <= 1'b0;
          last_int     <= int_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_silife_max7219.sv
// Bench for silife_max7219: a 16x8 chain and a default 32x32 chain, each with a
// SPI receiver that decodes CS-low windows against a queue of expected words.
module tb_silife_max7219;

  logic clk = 1'b0;
  logic rst_s_n, rst_b_n;
  always #5 clk = ~clk;

  silife_max7219_if #(.WIDTH(16), .HEIGHT(8)) bus_s ();
  silife_max7219_if bus_b ();

  silife_max7219 #(.WIDTH(16), .HEIGHT(8), .CLK_DIV(2)) u_dut_s (
    .clk(clk), .reset_n(rst_s_n), .bus(bus_s));
  silife_max7219 u_dut_b (
    .clk(clk), .reset_n(rst_b_n), .bus(bus_b));

  logic [15:0]  mem_s [8];
  logic [31:0]  mem_b [32];
  logic [255:0] q_s [$];
  logic [255:0] q_b [$];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) bus_s.row_data <= mem_s[bus_s.row_addr];
  always @(posedge clk) bus_b.row_data <= mem_b[bus_b.row_addr];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_w(input int i, input logic [3:0] inten);
    case (i)
      0:       return 16'h0F00;
      1:       return 16'h0B07;
      2:       return 16'h0900;
      3:       return {12'h0A0, inten};
      default: return 16'h0C01;
    endcase
  endfunction

  function automatic logic [255:0] rep(input bit big, input logic [15:0] w);
    logic [255:0] r = '0;
    for (int i = 0; i < (big ? 16 : 2); i++) r = {r[239:0], w};
    return r;
  endfunction

  // Devices leave the chain farthest-first, so device CHAIN-1 occupies the top word.
  function automatic logic [255:0] dig_win(input bit big, input int k);
    logic [255:0] w;
    logic [31:0]  r, t;
    logic [7:0]   b;
    int tw, tr, tc;
    w  = '0;
    tw = big ? 4 : 2;
    for (int d = (big ? 15 : 1); d >= 0; d--) begin
      tr = d / tw;
      tc = d % tw;
      r  = big ? mem_b[5'(tr*8 + k - 1)] : {16'h0, mem_s[3'(tr*8 + k - 1)]};
      for (int c = 0; c < 8; c++) begin
        t = r >> (tc*8 + c);
        b[3'(7 - c)] = t[0];
      end
      w = {w[239:0], 4'h0, 4'(k), b};
    end
    return w;
  endfunction

  // Small-chain receiver with SCK phase and CS gap timing.
  logic [31:0] sb_s;
  int nb_s, hi_s, lo_s, csh_s, tbad_s = 0, fd_s = 0;
  logic sck_q_s, cs_q_s;
  always @(negedge clk) begin
    if (!rst_s_n) begin
      nb_s = 0; hi_s = 0; lo_s = 0; csh_s = 0; sck_q_s = 1'b0; cs_q_s = 1'b1;
    end else begin
      if (bus_s.frame_done) fd_s++;
      if (!bus_s.spi_cs) begin
        if (bus_s.spi_sck && !sck_q_s) begin
          sb_s = {sb_s[30:0], bus_s.spi_mosi};
          nb_s++;
          if (lo_s < 2) tbad_s++;
          lo_s = 0;
        end
        if (!bus_s.spi_sck && sck_q_s) begin
          if (hi_s != 2) tbad_s++;
          hi_s = 0;
        end
        if (bus_s.spi_sck) hi_s++; else lo_s++;
        if (cs_q_s && csh_s > 0) begin
          if (csh_s != 4) tbad_s++;
          csh_s = 0;
        end
      end
      if (bus_s.spi_cs && bus_s.busy) csh_s++;
      if (bus_s.spi_cs && !cs_q_s) begin
        if (q_s.size() == 0) chk("win_s_extra", 1, 0);
        else begin
          chk("win_s", {224'h0, sb_s}, q_s.pop_front());
          chk("bits_s", nb_s, 32);
        end
        nb_s = 0; lo_s = 0; hi_s = 0;
      end
      sck_q_s = bus_s.spi_sck;
      cs_q_s  = bus_s.spi_cs;
    end
  end

  // Large-chain receiver.
  logic [255:0] sb_b;
  int nb_b, win_b, fd_b = 0;
  logic sck_q_b, cs_q_b;
  always @(negedge clk) begin
    if (!rst_b_n) begin
      nb_b = 0; win_b = 0; sck_q_b = 1'b0; cs_q_b = 1'b1;
    end else begin
      if (bus_b.frame_done) fd_b++;
      if (!bus_b.spi_cs && bus_b.spi_sck && !sck_q_b) begin
        sb_b = {sb_b[254:0], bus_b.spi_mosi};
        nb_b++;
      end
      if (bus_b.spi_cs && !cs_q_b) begin
        if (q_b.size() == 0) chk("win_b_extra", 1, 0);
        else begin
          chk("win_b", sb_b, q_b.pop_front());
          chk("bits_b", nb_b, 256);
        end
        if (win_b == 7) chk("dev0_dig3", sb_b[15:0], 16'h03C0);
        win_b++;
        nb_b = 0;
      end
      sck_q_b = bus_b.spi_sck;
      cs_q_b  = bus_b.spi_cs;
    end
  end

  task automatic wait_quiet_s(input string tag);
    int n = 0, q = 0;
    while (q < 6 && n < 20000) begin
      @(negedge clk);
      n++;
      q = bus_s.busy ? 0 : q + 1;
    end
    chk(tag, n < 20000, 1);
  endtask

  task automatic wait_quiet_b(input string tag);
    int n = 0, q = 0;
    while (q < 6 && n < 30000) begin
      @(negedge clk);
      n++;
      q = bus_b.busy ? 0 : q + 1;
    end
    chk(tag, n < 30000, 1);
  endtask

  task automatic req_s();
    bus_s.frame_req = 1'b1;
    @(negedge clk);
    bus_s.frame_req = 1'b0;
  endtask

  task automatic run_small();
    int n;
    for (int i = 0; i < 5; i++) q_s.push_back(rep(0, init_w(i, 4'h5)));
    rst_s_n = 1'b1;
    wait_quiet_s("init_s_tmo");
    chk("init_s_left", q_s.size(), 0);
    chk("init_s_fd", fd_s, 0);

    for (int k = 1; k <= 8; k++) q_s.push_back(dig_win(0, k));
    chk("frame1_model", q_s[0], 256'h01010180);
    req_s();
    wait_quiet_s("frame1_tmo");
    chk("frame1_left", q_s.size(), 0);
    chk("frame1_fd", fd_s, 1);

    bus_s.intensity = 4'hA;
    q_s.push_back(rep(0, 16'h0A0A));
    for (int k = 1; k <= 8; k++) q_s.push_back(dig_win(0, k));
    req_s();
    wait_quiet_s("frame2_tmo");
    chk("frame2_left", q_s.size(), 0);
    chk("frame2_fd", fd_s, 2);

    // Two extra requests plus a mid-frame intensity change: one more frame, new level there.
    for (int r = 0; r < 8; r++) mem_s[r] = 16'($urandom);
    for (int k = 1; k <= 8; k++) q_s.push_back(dig_win(0, k));
    q_s.push_back(rep(0, 16'h0A03));
    for (int k = 1; k <= 8; k++) q_s.push_back(dig_win(0, k));
    req_s();
    repeat (20) @(negedge clk);
    bus_s.intensity = 4'h3;
    repeat (40) @(negedge clk);
    req_s();
    repeat (30) @(negedge clk);
    req_s();
    wait_quiet_s("frame3_tmo");
    chk("frame3_left", q_s.size(), 0);
    chk("frame3_fd", fd_s, 4);

    req_s();
    n = 0;
    while (bus_s.spi_cs && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cs_low_tmo", n < 1000, 1);
    repeat (10) @(negedge clk);
    #1 rst_s_n = 1'b0;
    #1;
    chk("midrst_cs", bus_s.spi_cs, 1'b1);
    chk("midrst_sck", bus_s.spi_sck, 1'b0);
    chk("midrst_mosi", bus_s.spi_mosi, 1'b0);
    chk("midrst_busy", bus_s.busy, 1'b0);
    chk("midrst_addr", bus_s.row_addr, 0);
    q_s.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) q_s.push_back(rep(0, init_w(i, 4'h3)));
    rst_s_n = 1'b1;
    wait_quiet_s("reinit_tmo");
    chk("reinit_left", q_s.size(), 0);
    chk("reinit_fd", fd_s, 4);
  endtask

  task automatic run_big();
    for (int i = 0; i < 5; i++) q_b.push_back(rep(1, init_w(i, 4'h7)));
    rst_b_n = 1'b1;
    wait_quiet_b("init_b_tmo");
    chk("init_b_left", q_b.size(), 0);
    for (int r = 0; r < 32; r++) mem_b[r] = $urandom;
    mem_b[2][7:0] = 8'h03;
    for (int k = 1; k <= 8; k++) q_b.push_back(dig_win(1, k));
    bus_b.frame_req = 1'b1;
    @(negedge clk);
    bus_b.frame_req = 1'b0;
    wait_quiet_b("frame_b_tmo");
    chk("frame_b_left", q_b.size(), 0);
    chk("frame_b_fd", fd_b, 1);
  endtask

  initial begin
    rst_s_n = 1'b0;
    rst_b_n = 1'b0;
    bus_s.frame_req = 1'b0;
    bus_b.frame_req = 1'b0;
    bus_s.intensity = 4'h5;
    bus_b.intensity = 4'h7;
    for (int r = 0; r < 8; r++) mem_s[r] = 16'h0000;
    mem_s[0] = 16'h8001;
    for (int r = 0; r < 32; r++) mem_b[r] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cs", bus_s.spi_cs, 1'b1);
    chk("rst_sck", bus_s.spi_sck, 1'b0);
    chk("rst_mosi", bus_s.spi_mosi, 1'b0);
    chk("rst_busy", bus_s.busy, 1'b0);
    chk("rst_fd", bus_s.frame_done, 1'b0);
    chk("rst_addr", bus_s.row_addr, 0);
    chk("rst_cs_b", bus_b.spi_cs, 1'b1);
    fork
      run_small();
      run_big();
    join
    chk("sck_timing_s", tbad_s, 0);
    chk("q_s_empty", q_s.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/silife_max7219.md
Name: silife_max7219

Overview:
- Display stage downstream of the silife cell grid. Drives the SPI pins (spi_cs, spi_sck, spi_mosi) that feed a daisy-chain of MAX7219 8x8 LED matrix drivers.
- After reset, sends the MAX7219 configuration words. On each frame request, reads grid rows through a fixed-latency row port and shifts out all 8 digit registers to every device in the chain.
- Chain length CHAIN = (WIDTH/8)*(HEIGHT/8). Device d = tile_row*(WIDTH/8) + tile_col.

Parameters:
- WIDTH, 32, grid columns; multiple of 8.
- HEIGHT, 32, grid rows; multiple of 8.
- CLK_DIV, 2, clk cycles per SCK half-period; at least 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_req  in  1  single-cycle pulse requesting a display refresh.
- intensity  in  4  MAX7219 intensity value.
- row_addr  out  $clog2(HEIGHT)  grid row being read.
- row_data  in  WIDTH  cell row; row_data[c] = column c; valid 1 clk after row_addr.
- busy  out  1  high whenever not IDLE.
- frame_done  out  1  single-cycle pulse at the end of a frame.
- spi_cs  out  1  chip select, active low (MAX7219 LOAD).
- spi_sck  out  1  serial clock.
- spi_mosi  out  1  serial data, MSB first.

Behaviour:
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, busy=0, frame_done=0, row_addr=0. State IDLE; init_pending=1; frame_pending=0; last intensity register=0.
- Reset asserted mid-transfer: outputs return to reset values immediately; the init sequence is redone after release.
- States: IDLE, FETCH, CAPTURE, SHIFT, TAIL, GAP.
- One "chain word" = CHAIN device words of 16 bits each ({4'h0, addr[3:0], data[7:0]}), sent under one CS-low window. The first device word shifted reaches device CHAIN-1 (farthest).
- IDLE:
  - If init_pending, start the init sequence. Else if frame_pending, start a frame. Otherwise stay.
  - Init words, in order, with every device given the same word: 0x0F00, 0x0B07, 0x0900, 0x0A0{intensity}, 0x0C01. Completing init clears init_pending and loads last intensity; no frame_done pulse.
  - Frame: if intensity differs from last intensity, first send 0x0A0{intensity} to all devices and update last intensity. Then send digits k=1..8.
  - Digit-k data for device d comes from row tile_row*8+k-1. Data bit7 = column tile_col*8; bit0 = column tile_col*8+7.
- FETCH (1 clk): drive row_addr for the current device word; digit words only.
- CAPTURE (1 clk): register the 16-bit device word into the shifter.
  - Config words skip FETCH and enter CAPTURE directly.
- SHIFT:
  - spi_cs=0 from the first cycle of the first device word of a chain word.
  - Each bit: SCK low for CLK_DIV clk with mosi updated on entry, then SCK high for CLK_DIV clk.
  - After bit 0 of a device word: go back to FETCH/CAPTURE for the next device, with spi_cs held low and spi_sck low. Any added low time is allowed.
  - After the last device word, go to TAIL.
- TAIL: CLK_DIV clk with spi_sck=0 and spi_cs=0.
- GAP: spi_cs=1 for 2*CLK_DIV clk. The MAX7219 latches on the rising edge of CS.
- After GAP: go to the next chain word or to IDLE. On completion of digit 8, pulse frame_done for 1 clk as IDLE is entered.
- frame_req:
  - Sets frame_pending in any state; pending depth is 1, so extra requests while pending merge.
  - Cleared when the frame starts. A request arriving during a frame causes exactly one further frame.
  - A request during init is served after init completes.
- intensity is sampled only at frame start; changes mid-frame are ignored until the next frame.
- Row reads happen only in FETCH; row_addr holds its value otherwise.

Decomposition:
- Package silife_pkg holds:
  - MAX7219 register address constants: DIGIT0=1, DECODE=9, INTENSITY=10, SCANLIMIT=11, SHUTDOWN=12, TEST=15.
  - The init word list.
  - The state enum typedef.
- Sub-module silife_spi_shifter:
  - Serializes one 16-bit word, generating SCK from CLK_DIV.
  - Handshake: start/ready; done pulses after the final high phase.
  - The parent owns spi_cs and sequencing.

Test Plan:
- Reset release, WIDTH=16, HEIGHT=8, CLK_DIV=2, intensity=4'h5 -> five CS-low windows of 32 bits: 0x0F000F00, 0x0B070B07, 0x09000900, 0x0A050A05, 0x0C010C01. Each window has SCK period 4 clk and CS high for 4 clk between windows. busy=1 throughout, no frame_done.
- Same config, row 0 = 16'h8001, other rows 0, frame_req -> first digit window 0x01010180, digits 2..8 0x0k000k00, then one frame_done pulse. No intensity word is sent.
- Change intensity to 4'hA, frame_req -> first window 0x0A0A0A0A, then 8 digit windows.
- frame_req pulsed twice during a frame -> exactly one extra frame, two frame_done pulses total.
- Defaults 32x32: check CHAIN=16 windows of 256 bits. Device 0 digit 3 data comes from row 2, columns 0..7.
- Assert reset_n mid-SHIFT -> spi_cs=1, spi_sck=0 the same cycle. After release the full init sequence repeats.
